// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg: shared state encoding and constants for the pipeline hazard/stall controller.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {IDLE, RUN, MEMWAIT} state_t;

    localparam logic [4:0] X0 = 5'd0;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// pipeline_ctrl_if: pipeline-side signals seen by the hazard/stall controller.
interface pipeline_ctrl_if #(parameter int CNT_W = 16);

    logic             start_i;
    logic             EX_MemRead_i;
    logic [4:0]       EX_rd_i;
    logic [4:0]       ID_rs1_i;
    logic [4:0]       ID_rs2_i;
    logic             ID_useRs2_i;
    logic             ID_branchTaken_i;
    logic             mem_req_i;
    logic             mem_ack_i;
    logic             dcache_req_o;
    logic             PCWrite_o;
    logic             IFIDWrite_o;
    logic             Flush_o;
    logic             NoOp_o;
    logic             MemStall_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic [CNT_W-1:0] flush_cnt_o;
    logic             err_o;

    modport master (
        output start_i, EX_MemRead_i, EX_rd_i, ID_rs1_i, ID_rs2_i, ID_useRs2_i,
               ID_branchTaken_i, mem_req_i, mem_ack_i,
        input  dcache_req_o, PCWrite_o, IFIDWrite_o, Flush_o, NoOp_o, MemStall_o,
               stall_cnt_o, flush_cnt_o, err_o
    );

    modport slave (
        input  start_i, EX_MemRead_i, EX_rd_i, ID_rs1_i, ID_rs2_i, ID_useRs2_i,
               ID_branchTaken_i, mem_req_i, mem_ack_i,
        output dcache_req_o, PCWrite_o, IFIDWrite_o, Flush_o, NoOp_o, MemStall_o,
               stall_cnt_o, flush_cnt_o, err_o
    );

endinterface

// File: rtl/pipeline_hazard_detect.sv
// pipeline_hazard_detect: combinational load-use compare, reusable by forwarding checks.
module pipeline_hazard_detect
    import pipeline_ctrl_pkg::*;
(
    input  logic       mem_read,
    input  logic [4:0] rd,
    input  logic [4:0] rs1,
    input  logic [4:0] rs2,
    input  logic       use_rs2,
    output logic       lu
);

    assign lu = mem_read && rd != X0 && (rd == rs1 || (use_rs2 && rd == rs2));

endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: FSM, stall/flush priority mux, saturating perf counters and memory timeout.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    pipeline_ctrl_if.slave   bus
);

    localparam int TW = $clog2(MEM_TIMEOUT + 1);

    state_t           state, state_nxt;
    logic             lu, ms, active;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic [TW-1:0]    tcnt;
    logic             err;

    pipeline_hazard_detect u_hazard (
        .mem_read (bus.EX_MemRead_i),
        .rd       (bus.EX_rd_i),
        .rs1      (bus.ID_rs1_i),
        .rs2      (bus.ID_rs2_i),
        .use_rs2  (bus.ID_useRs2_i),
        .lu       (lu)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    // Memory stall outranks load-use, which outranks a taken branch.
    always_comb begin
        active    = state != IDLE;
        ms        = active && bus.mem_req_i && !bus.mem_ack_i;
        state_nxt = state == IDLE ? (bus.start_i ? RUN : IDLE) :
                    state == RUN  ? (ms ? MEMWAIT : RUN) :
                    state == MEMWAIT ? ((bus.mem_req_i && bus.mem_ack_i) ? RUN : MEMWAIT) : IDLE;
        bus.dcache_req_o = active && bus.mem_req_i;
        bus.MemStall_o   = ms;
        bus.PCWrite_o    = active && !ms && !lu;
        bus.IFIDWrite_o  = active && !ms && !lu;
        bus.NoOp_o       = !active || (!ms && lu);
        bus.Flush_o      = active && !ms && !lu && bus.ID_branchTaken_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
            tcnt      <= '0;
            err       <= 1'b0;
        end else begin
            if (active && (ms || lu) && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
            if (bus.Flush_o && !(&flush_cnt))          flush_cnt <= flush_cnt + 1'b1;
            if (state == RUN && ms)
                tcnt <= '0;
            else if (state == MEMWAIT && tcnt != TW'(MEM_TIMEOUT))
                tcnt <= tcnt + 1'b1;
            if (state == MEMWAIT && tcnt == TW'(MEM_TIMEOUT - 1)) err <= 1'b1;
        end
    end

    assign bus.stall_cnt_o = stall_cnt;
    assign bus.flush_cnt_o = flush_cnt;
    assign bus.err_o       = err;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: vector table, hand-written corner sequences and random run against a reference model.
module tb_pipeline_ctrl;

    localparam int CW  = 4;
    localparam int TMO = 4;
    localparam int SAT = (1 << CW) - 1;

    logic clk = 0;
    logic rst;
    always #5 clk = ~clk;

    pipeline_ctrl_if #(.CNT_W(CW)) bus ();

    pipeline_ctrl #(.CNT_W(CW), .MEM_TIMEOUT(TMO)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    typedef struct {
        logic       start, mr;
        logic [4:0] rd, rs1, rs2;
        logic       u2, br, rq, ak;
        logic [5:0] exp;
    } vec_t;

    int pass_cnt = 0;
    int total    = 0;

    // reference model: running flag, waiting-for-cache flag, cycles waited
    int   m_run, m_wait, m_tw, m_scnt, m_fcnt, m_err;
    logic e_lu, e_ms, e_fl;
    logic h_rst, h_start, h_rq, h_ak;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        else pass_cnt++;
    endtask

    function automatic logic [5:0] ctrl_act();
        return {bus.dcache_req_o, bus.PCWrite_o, bus.IFIDWrite_o, bus.Flush_o, bus.NoOp_o, bus.MemStall_o};
    endfunction

    function automatic logic [15:0] cnt_act();
        return 16'({bus.stall_cnt_o, bus.flush_cnt_o, bus.err_o});
    endfunction

    task automatic apply(input logic r, st, mr, input logic [4:0] rd, rs1, rs2,
                         input logic u2, br, rq, ak, input bit chk);
        logic [5:0] e;
        rst = r; bus.start_i = st; bus.EX_MemRead_i = mr; bus.EX_rd_i = rd;
        bus.ID_rs1_i = rs1; bus.ID_rs2_i = rs2; bus.ID_useRs2_i = u2;
        bus.ID_branchTaken_i = br; bus.mem_req_i = rq; bus.mem_ack_i = ak;
        h_rst = r; h_start = st; h_rq = rq; h_ak = ak;
        #1;
        e_lu = mr && rd != 0 && (rd == rs1 || (u2 && rd == rs2));
        e_ms = m_run != 0 && rq && !ak;
        e_fl = m_run != 0 && !e_ms && !e_lu && br;
        if (m_run == 0) e = 6'b000010;
        else if (e_ms)  e = 6'b100001;
        else if (e_lu)  e = {rq, 5'b00010};
        else            e = {rq, 2'b11, br, 2'b00};
        if (chk) begin
            check("model_ctrl", 16'(ctrl_act()), 16'(e));
            check("model_cnt", cnt_act(), 16'({m_scnt[CW-1:0], m_fcnt[CW-1:0], m_err[0]}));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (h_rst) begin
            m_run = 0; m_wait = 0; m_tw = 0; m_scnt = 0; m_fcnt = 0; m_err = 0;
        end else if (m_run == 0) begin
            m_run = h_start ? 1 : 0;
        end else begin
            if (e_ms || e_lu) m_scnt = (m_scnt < SAT) ? m_scnt + 1 : SAT;
            if (e_fl)         m_fcnt = (m_fcnt < SAT) ? m_fcnt + 1 : SAT;
            if (m_wait != 0) begin
                m_tw++;
                if (m_tw == TMO) m_err = 1;
                if (h_rq && h_ak) m_wait = 0;
            end else if (e_ms) begin
                m_wait = 1;
                m_tw = 0;
            end
        end
        #1;
    endtask

    task automatic restart();
        apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1); tick();
        apply(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1); tick();
    endtask

    vec_t tbl[14];

    initial begin
        tbl[0]  = '{0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 6'b000010};
        tbl[1]  = '{1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 6'b000010};
        tbl[2]  = '{0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 6'b011000};
        tbl[3]  = '{0, 1, 5'd5, 5'd1, 5'd5, 1, 0, 0, 0, 6'b000010};
        tbl[4]  = '{0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 6'b011000};
        tbl[5]  = '{0, 1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 6'b011000};
        tbl[6]  = '{0, 1, 5'd5, 5'd1, 5'd5, 0, 0, 0, 0, 6'b011000};
        tbl[7]  = '{0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, 6'b011100};
        tbl[8]  = '{0, 1, 5'd3, 5'd3, 5'd0, 0, 1, 0, 0, 6'b000010};
        tbl[9]  = '{0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1, 6'b111000};
        tbl[10] = '{0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 1, 0, 6'b100001};
        tbl[11] = '{0, 1, 5'd3, 5'd3, 5'd0, 0, 0, 1, 0, 6'b100001};
        tbl[12] = '{0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 1, 1, 6'b111100};
        tbl[13] = '{0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 6'b011000};
        m_run = 0; m_wait = 0; m_tw = 0; m_scnt = 0; m_fcnt = 0; m_err = 0;
        apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
        apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
        for (int i = 0; i < 14; i++) begin
            apply(0, tbl[i].start, tbl[i].mr, tbl[i].rd, tbl[i].rs1, tbl[i].rs2,
                  tbl[i].u2, tbl[i].br, tbl[i].rq, tbl[i].ak, 1);
            check($sformatf("tbl%0d_ctrl", i), 16'(ctrl_act()), 16'(tbl[i].exp));
            tick();
        end
        check("tbl_stall_cnt", 16'(bus.stall_cnt_o), 16'd4);
        check("tbl_flush_cnt", 16'(bus.flush_cnt_o), 16'd2);

        // ten-cycle miss: stalled from request until the ack cycle
        restart();
        for (int i = 0; i < 10; i++) begin
            apply(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
            check("miss_stall", 16'(bus.MemStall_o), 16'd1);
            tick();
        end
        apply(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
        check("miss_ack_stall", 16'(bus.MemStall_o), 16'd0);
        check("miss_stall_cnt", 16'(bus.stall_cnt_o), 16'd10);
        tick();

        // timeout: err visible once four wait cycles have elapsed
        restart();
        for (int k = 0; k < 8; k++) begin
            apply(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
            check($sformatf("tmo_err_c%0d", k), 16'(bus.err_o), (k >= 5) ? 16'd1 : 16'd0);
            check("tmo_stall", 16'(bus.MemStall_o), 16'd1);
            tick();
        end
        apply(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
        check("tmo_ack_stall", 16'(bus.MemStall_o), 16'd0);
        tick();
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        check("tmo_err_sticky", 16'(bus.err_o), 16'd1);
        tick();

        // reset in the middle of a wait
        restart();
        for (int k = 0; k < 3; k++) begin apply(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1); tick(); end
        apply(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1); tick();
        apply(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
        check("rstw_idle_ctrl", 16'(ctrl_act()), 16'b000010);
        check("rstw_cnt", cnt_act(), 16'd0);
        tick();
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        check("rstw_after_ack", cnt_act(), 16'd0);
        check("rstw_noop", 16'(bus.NoOp_o), 16'd1);
        tick();

        // saturation
        restart();
        for (int k = 0; k < 20; k++) begin apply(0, 0, 1, 5'd7, 5'd7, 5'd0, 0, 1, 0, 0, 1); tick(); end
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        check("sat_stall_cnt", 16'(bus.stall_cnt_o), 16'(SAT));
        tick();

        // random run against the model
        restart();
        for (int k = 0; k < 400; k++) begin
            apply(($urandom % 60) == 0, ($urandom % 4) != 0, $urandom % 2,
                  5'($urandom % 4), 5'($urandom % 4), 5'($urandom % 4),
                  $urandom % 2, ($urandom % 4) == 0, ($urandom % 3) != 0,
                  ($urandom % 4) == 0, 1);
            tick();
        end

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central hazard and stall controller for the 5-stage pipeline. Sequences the PC, IF/ID and ID/EX registers: generates load-use bubbles, branch flushes and data-cache stalls, and runs the data-cache request handshake. Sits beside the hazard datapath, driving the PCWrite, IF/ID write/flush, ID/EX NoOp and the global MemStall seen by every pipeline register. It also keeps saturating performance counters and a sticky memory-timeout flag.

## Interface
- CNT_W, 16, width of the stall and flush performance counters
- MEM_TIMEOUT, 64, MEMWAIT cycle count at which err_o sets
- clk_i  in  1  clock
- rst_i  in  1  reset; one clock, synchronous, active-high
- start_i  in  1  CPU start; the pipeline holds in IDLE while low
- EX_MemRead_i  in  1  MemRead of the instruction in the ID/EX register
- EX_rd_i  in  5  rd of the instruction in ID/EX
- ID_rs1_i, ID_rs2_i  in  5 each  source registers of the instruction in IF/ID
- ID_useRs2_i  in  1  instruction in IF/ID reads rs2
- ID_branchTaken_i  in  1  branch resolved taken in ID
- mem_req_i  in  1  instruction in EX/MEM has MemRead or MemWrite set
- mem_ack_i  in  1  data-cache completion; one-cycle pulse
- dcache_req_o  out  1  request to the data cache
- PCWrite_o  out  1  PC update enable
- IFIDWrite_o  out  1  IF/ID update enable
- Flush_o  out  1  clear IF/ID
- NoOp_o  out  1  zero the ID/EX control fields
- MemStall_o  out  1  freeze all pipeline registers
- stall_cnt_o  out  CNT_W  cycles with MemStall_o or a load-use stall, saturating
- flush_cnt_o  out  CNT_W  cycles with Flush_o, saturating
- err_o  out  1  sticky memory-timeout flag

## Operation
- States: IDLE, RUN, MEMWAIT. The state register is the only sequential element besides the counters, the timeout counter and err_o.
- IDLE:
  - Outputs: PCWrite_o = IFIDWrite_o = 0, NoOp_o = 1, Flush_o = MemStall_o = dcache_req_o = 0.
  - Transition: start_i = 1 -> RUN on the next edge.
- A load-use hazard (lu) is true when all of these hold:
  - EX_MemRead_i = 1
  - EX_rd_i != 0
  - EX_rd_i == ID_rs1_i, or (ID_useRs2_i = 1 and EX_rd_i == ID_rs2_i)
- RUN and MEMWAIT:
  - dcache_req_o = mem_req_i.
  - MemStall_o = mem_req_i & ~mem_ack_i.
- Output priority in RUN and MEMWAIT:
  - MemStall_o = 1: PCWrite_o = IFIDWrite_o = 0, NoOp_o = 0, Flush_o = 0. The pipeline is frozen and lu or branch handling is deferred.
  - Else lu: PCWrite_o = IFIDWrite_o = 0, NoOp_o = 1, Flush_o = 0. A taken branch is resolved again on the next cycle.
  - Else ID_branchTaken_i: PCWrite_o = IFIDWrite_o = 1, Flush_o = 1, NoOp_o = 0.
  - Else: PCWrite_o = IFIDWrite_o = 1, Flush_o = NoOp_o = 0.
- Transitions:
  - RUN -> MEMWAIT when mem_req_i & ~mem_ack_i.
  - MEMWAIT -> RUN on mem_ack_i; the pipeline advances on that same edge.
  - A request acked in its first cycle never leaves RUN.
- Timeout:
  - tcnt counts MEMWAIT cycles and clears on entry to MEMWAIT.
  - When tcnt reaches MEM_TIMEOUT, err_o = 1 until reset.
  - The stall is not released by a timeout.
- Counters: increment by 1 per qualifying cycle and saturate at all-ones.
- mem_ack_i in IDLE, or while mem_req_i = 0, is ignored.
- start_i falling after IDLE has no effect; only reset returns the block to IDLE.

## Timing
- All control outputs are combinational from the current inputs and state: zero-cycle latency to the pipeline registers.
- Reset, synchronous on clk_i:
  - State = IDLE; stall_cnt_o = flush_cnt_o = 0, err_o = 0, tcnt = 0.
  - Outputs then follow the IDLE values, including NoOp_o = 1.
- Reset asserted mid-MEMWAIT returns to IDLE on that edge; any later ack is ignored.
- Counters and err_o update on the edge ending the qualifying cycle and are visible the following cycle.
- A one-cycle load-use bubble costs exactly one cycle.
- A cache miss stalls for the cycles from the request to its ack; the ack cycle itself is not stalled.

## Structure
- Package pipeline_ctrl_pkg holds:
  - The state enum (IDLE, RUN, MEMWAIT).
  - The x0 register index constant.
- Sub-module pipeline_hazard_detect: purely combinational lu compare, so the same compare can be reused by forwarding checks.
- Top level: the FSM, the output priority mux, the counters and the timeout logic.

## Test plan
- Start-up: rst_i = 1 for 2 cycles, start_i = 0 -> NoOp_o = 1, PCWrite_o = 0. Raise start_i -> RUN next cycle, PCWrite_o = 1.
- Load-use: EX_MemRead_i = 1, EX_rd_i = 5, ID_rs2_i = 5, ID_useRs2_i = 1 for 1 cycle -> PCWrite_o = IFIDWrite_o = 0, NoOp_o = 1 for one cycle; stall_cnt_o = 1. With EX_rd_i = 0 -> no stall.
- Branch: ID_branchTaken_i = 1 alone -> Flush_o = 1 for 1 cycle, flush_cnt_o = 1. Branch together with lu -> Flush_o = 0 that cycle.
- Cache miss: mem_req_i = 1, ack after 10 cycles -> MemStall_o high for exactly 10 cycles, then low in the ack cycle; stall_cnt_o = 10. Ack in the request cycle -> MemStall_o never asserts.
- Timeout: MEM_TIMEOUT = 4, ack withheld for 8 cycles -> err_o set after cycle 4, MemStall_o stays high until the ack, err_o stays 1 after the ack.
- Reset in MEMWAIT: rst_i pulsed at wait cycle 3 -> IDLE, counters = 0, a later mem_ack_i causes no change. Counter saturation with CNT_W = 4 -> stall_cnt_o holds at 15.
